// File: rtl/uart_apb_tx_rx_sched.sv
// APB master sequencer for one CoreUARTapb: writes the control registers once after reset,
// shares the transmitter round-robin between byte requesters, and drains RX bytes into a one-entry buffer.
module uart_apb_tx_rx_sched #(
  parameter int          NUM_REQ    = 4,
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter bit          PRG_BIT8   = 1'b1,
  parameter int          PRG_PARITY = 0,
  parameter int          GUARD      = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  output logic [4:0]           PADDR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [7:0]           PWDATA,
  input  logic [7:0]           PRDATA,
  input  logic                 TXRDY,
  input  logic                 RXRDY,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 init_done,
  output logic [2:0]           last_grant
);

  localparam logic [4:0] ADDR_TX = 5'h00;
  localparam logic [4:0] ADDR_RX = 5'h04;
  localparam logic [4:0] ADDR_C1 = 5'h08;
  localparam logic [4:0] ADDR_C2 = 5'h0C;
  localparam logic       PAR_ODD = (PRG_PARITY == 2);
  localparam logic       PAR_EN  = (PRG_PARITY != 0);
  localparam logic       BIT8    = PRG_BIT8;
  localparam logic [7:0] CTRL1   = BAUD_VALUE[7:0];
  localparam logic [7:0] CTRL2   = {BAUD_VALUE[12:8], PAR_ODD, PAR_EN, BIT8};
  localparam logic [3:0] NREQ    = 4'(NUM_REQ);
  localparam logic [2:0] GLAST   = 3'(GUARD - 1);

  typedef enum logic [2:0] {
    INIT1, INIT2, IDLE, TX_SET, TX_ACC, RX_SET, RX_ACC, GUARD_W
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic [2:0]           gcnt_q, gcnt_d;
  logic [2:0]           grant_q, grant_d;
  logic [7:0]           txbyte_q, txbyte_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [4:0]           paddr_q, paddr_d;
  logic [7:0]           pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [2:0]           lastg_q, lastg_d;
  logic                 initdone_q, initdone_d;
  logic                 rxv_q, rxv_d;
  logic [7:0]           rxd_q, rxd_d;

  logic [7:0]  vld8;
  logic [63:0] dat64;
  logic        found;
  logic [2:0]  sel;
  logic [3:0]  cand;
  logic [7:0]  sel_byte;
  logic [7:0]  grant_oh;

  // Round-robin search: first valid requester after the last one granted, wrapping at NUM_REQ.
  always_comb begin
    vld8 = '0;
    vld8[NUM_REQ-1:0] = req_valid;
    dat64 = '0;
    dat64[8*NUM_REQ-1:0] = req_data;
    found = 1'b0;
    sel = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, lastg_q} + 4'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && vld8[cand[2:0]]) begin
        found = 1'b1;
        sel = cand[2:0];
      end
    end
    sel_byte = dat64[{sel, 3'b000} +: 8];
  end

  // INIT1 uses step 0 as the reset-exit cycle; steps 1/2 are the APB setup/access phases.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gcnt_d   = gcnt_q;
    grant_d  = grant_q;
    txbyte_d = txbyte_q;
    case (state_q)
      INIT1: begin
        if (step_q == 2'd2) begin
          state_d = INIT2;
          step_d  = 2'd1;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      INIT2: begin
        if (step_q == 2'd2) begin
          state_d = GUARD_W;
          gcnt_d  = '0;
        end else begin
          step_d = 2'd2;
        end
      end
      IDLE: begin
        if (RXRDY && !rxv_q) begin
          state_d = RX_SET;
        end else if (TXRDY && found) begin
          state_d  = TX_SET;
          grant_d  = sel;
          txbyte_d = sel_byte;
        end
      end
      TX_SET: state_d = TX_ACC;
      TX_ACC: begin
        state_d = GUARD_W;
        gcnt_d  = '0;
      end
      RX_SET: state_d = RX_ACC;
      RX_ACC: begin
        state_d = GUARD_W;
        gcnt_d  = '0;
      end
      GUARD_W: begin
        if (gcnt_q == GLAST) state_d = IDLE;
        else gcnt_d = gcnt_q + 3'd1;
      end
      default: begin
        state_d = INIT1;
        step_d  = '0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_ready_d = '0;
    grant_oh    = 8'd1 << grant_d;
    case (state_d)
      INIT1, INIT2: begin
        if (step_d != 2'd0) begin
          psel_d    = 1'b1;
          pwrite_d  = 1'b1;
          penable_d = (step_d == 2'd2);
          paddr_d   = (state_d == INIT1) ? ADDR_C1 : ADDR_C2;
          pwdata_d  = (state_d == INIT1) ? CTRL1 : CTRL2;
        end
      end
      TX_SET, TX_ACC: begin
        psel_d    = 1'b1;
        pwrite_d  = 1'b1;
        penable_d = (state_d == TX_ACC);
        paddr_d   = ADDR_TX;
        pwdata_d  = txbyte_d;
      end
      RX_SET, RX_ACC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == RX_ACC);
        paddr_d   = ADDR_RX;
      end
      default: ;
    endcase
    if (state_d == TX_ACC) req_ready_d = grant_oh[NUM_REQ-1:0];
    lastg_d    = (state_q == TX_ACC) ? grant_q : lastg_q;
    initdone_d = initdone_q | ((state_q == INIT2) && (state_d == GUARD_W));
    rxv_d      = rxv_q;
    rxd_d      = rxd_q;
    if (state_q == RX_ACC) begin
      rxv_d = 1'b1;
      rxd_d = PRDATA;
    end else if (rxv_q && rx_ready) begin
      rxv_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= INIT1;
      step_q      <= '0;
      gcnt_q      <= '0;
      grant_q     <= '0;
      txbyte_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ready_q <= '0;
      lastg_q     <= 3'(NUM_REQ - 1);
      initdone_q  <= 1'b0;
      rxv_q       <= 1'b0;
      rxd_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      gcnt_q      <= gcnt_d;
      grant_q     <= grant_d;
      txbyte_q    <= txbyte_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      lastg_q     <= lastg_d;
      initdone_q  <= initdone_d;
      rxv_q       <= rxv_d;
      rxd_q       <= rxd_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign req_ready  = req_ready_q;
  assign last_grant = lastg_q;
  assign init_done  = initdone_q;
  assign rx_valid   = rxv_q;
  assign rx_data    = rxd_q;

endmodule

// File: tb/tb_uart_apb_tx_rx_sched.sv
// Self-checking bench for uart_apb_tx_rx_sched: a transaction-level model checks every APB access
// and the RX buffer each cycle, while directed scenarios pin ordering, latency and reset behaviour.
module tb_uart_apb_tx_rx_sched;
  localparam int NUM_REQ = 4;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [4:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        TXRDY, RXRDY;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        init_done;
  logic [2:0]  last_grant;

  uart_apb_tx_rx_sched #(
    .NUM_REQ(NUM_REQ), .BAUD_VALUE(13'h123), .PRG_BIT8(1'b1), .PRG_PARITY(2), .GUARD(2)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .TXRDY(TXRDY), .RXRDY(RXRDY),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .init_done(init_done), .last_grant(last_grant)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Model state and transaction logs
  int         m_lg = NUM_REQ - 1;
  bit         m_rxv = 1'b0;
  logic [7:0] m_rxd = 8'h00;
  int         m_wcnt = 0;
  bit         m_init = 1'b0;
  int         n_acc = 0, n_wr = 0, n_rd = 0, n_tx = 0;
  int         acc_cyc[256];
  bit         acc_wr[256];
  logic [4:0] acc_addr[256];
  logic [7:0] acc_data[256];
  int         t_cyc[256];
  int         g_log[256];
  logic [7:0] t_data[256];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected grant: first requester with valid set, scanning upward from last+1 with wrap.
  function automatic int rrPick(input int last, input logic [3:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Compare process: checks the DUT against the model on every clock while out of reset.
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      m_lg = NUM_REQ - 1;
      m_rxv = 1'b0;
      m_rxd = 8'h00;
      m_wcnt = 0;
      m_init = 1'b0;
    end else begin
      bit full;
      int g;
      checkOutput("rx_valid", rx_valid, m_rxv);
      if (m_rxv) checkOutput("rx_data", rx_data, m_rxd);
      checkOutput("init_done", init_done, m_init);
      checkOutput("last_grant", last_grant, m_lg);
      full = m_rxv;
      if (m_rxv && rx_ready) m_rxv = 1'b0;
      if (PSEL && PENABLE) begin
        if (n_acc < 256) begin
          acc_cyc[n_acc]  = cyc;
          acc_wr[n_acc]   = PWRITE;
          acc_addr[n_acc] = PADDR;
          acc_data[n_acc] = PWRITE ? PWDATA : PRDATA;
        end
        n_acc++;
        if (PWRITE) begin
          n_wr++;
          if (m_wcnt < 2) begin
            checkOutput("init_addr", PADDR, (m_wcnt == 0) ? 5'h08 : 5'h0C);
            checkOutput("init_data", PWDATA, (m_wcnt == 0) ? 8'h23 : 8'h0F);
            checkOutput("init_req_ready", req_ready, 4'b0000);
            m_wcnt++;
            if (m_wcnt == 2) m_init = 1'b1;
          end else begin
            g = rrPick(m_lg, req_valid);
            checkOutput("tx_addr", PADDR, 5'h00);
            checkOutput("tx_req_ready", req_ready, (g >= 0) ? (4'b0001 << g) : 4'b0000);
            if (g >= 0) begin
              checkOutput("tx_data", PWDATA, req_data[8*g +: 8]);
              if (n_tx < 256) begin
                t_cyc[n_tx]  = cyc;
                g_log[n_tx]  = g;
                t_data[n_tx] = PWDATA;
              end
              n_tx++;
              m_lg = g;
            end
          end
        end else begin
          n_rd++;
          checkOutput("rx_addr", PADDR, 5'h04);
          checkOutput("read_while_full", full, 1'b0);
          checkOutput("rx_req_ready", req_ready, 4'b0000);
          m_rxv = 1'b1;
          m_rxd = PRDATA;
        end
      end else begin
        checkOutput("req_ready_idle", req_ready, 4'b0000);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] rv, input logic txr, input logic rxr,
                               input logic [7:0] prd, input logic rrdy);
    req_valid = rv;
    TXRDY     = txr;
    RXRDY     = rxr;
    PRDATA    = prd;
    rx_ready  = rrdy;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic waitTx(input string name, input int target, input int budget);
    int b;
    b = budget;
    while (n_tx < target && b > 0) begin
      stepCycles(1);
      b--;
    end
    checkOutput(name, (n_tx >= target), 1'b1);
  endtask

  initial begin
    int base, a0, r0, w0, t0, tv, b;
    int exp_g[5];
    logic [7:0] exp_d[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset values
    #23;
    checkOutput("rst_psel", PSEL, 1'b0);
    checkOutput("rst_penable", PENABLE, 1'b0);
    checkOutput("rst_pwrite", PWRITE, 1'b0);
    checkOutput("rst_paddr", PADDR, 5'h00);
    checkOutput("rst_pwdata", PWDATA, 8'h00);
    checkOutput("rst_req_ready", req_ready, 4'b0000);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_init_done", init_done, 1'b0);
    checkOutput("rst_last_grant", last_grant, 3'd3);
    @(posedge PCLK);
    #2 PRESETN = 1'b1;

    // Init sequence then quiet bus
    stepCycles(20);
    checkOutput("init_write_count", n_wr, 2);
    checkOutput("init_read_count", n_rd, 0);
    checkOutput("init_w0_addr", acc_addr[0], 5'h08);
    checkOutput("init_w0_data", acc_data[0], 8'h23);
    checkOutput("init_w1_addr", acc_addr[1], 5'h0C);
    checkOutput("init_w1_data", acc_data[1], 8'h0F);
    checkOutput("init_spacing", acc_cyc[1] - acc_cyc[0], 2);
    checkOutput("init_done_set", init_done, 1'b1);
    checkOutput("init_bus_idle", PSEL, 1'b0);

    // All four requesting: grants rotate 0,1,2,3,0
    base = n_tx;
    applyStimulus(4'b1111, 1'b1, 1'b0, 8'h00, 1'b0);
    waitTx("rr_wait", base + 5, 100);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), g_log[base+i], exp_g[i]);
      checkOutput($sformatf("rr_data%0d", i), t_data[base+i], exp_d[i]);
    end
    checkOutput("rr_period", t_cyc[base+1] - t_cyc[base], 5);
    stepCycles(10);
    checkOutput("rr_count", n_tx - base, 5);

    // TXRDY low blocks; rise gives one write of byte 2 two cycles later
    base = n_tx;
    a0 = n_acc;
    applyStimulus(4'b0100, 1'b0, 1'b0, 8'h00, 1'b0);
    stepCycles(12);
    checkOutput("txrdy_low_no_access", n_acc - a0, 0);
    t0 = cyc;
    applyStimulus(4'b0100, 1'b1, 1'b0, 8'h00, 1'b0);
    waitTx("txrdy_wait", base + 1, 20);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("tx_latency", t_cyc[base] - t0, 2);
    checkOutput("tx_grant2", g_log[base], 2);
    checkOutput("tx_byte2", t_data[base], 8'h33);
    stepCycles(10);
    checkOutput("tx_single", n_tx - base, 1);

    // RX read, buffer held until consumer accepts
    r0 = n_rd;
    t0 = cyc;
    tv = -1;
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'hA5, 1'b0);
    b = 20;
    while (!rx_valid && b > 0) begin
      stepCycles(1);
      b--;
    end
    if (rx_valid) tv = cyc;
    checkOutput("rx_latency", tv - t0, 3);
    stepCycles(15);
    checkOutput("rx_one_read", n_rd - r0, 1);
    checkOutput("rx_held_valid", rx_valid, 1'b1);
    checkOutput("rx_held_data", rx_data, 8'hA5);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h5A, 1'b1);
    stepCycles(1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h5A, 1'b0);
    stepCycles(15);
    checkOutput("rx_second_read", n_rd - r0, 2);
    checkOutput("rx_second_data", rx_data, 8'h5A);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    stepCycles(8);
    checkOutput("rx_drained", rx_valid, 1'b0);

    // RX and TX ready together: read first, write after the guard
    base = n_tx;
    a0 = n_acc;
    applyStimulus(4'b0001, 1'b1, 1'b1, 8'h3C, 1'b0);
    waitTx("prio_wait", base + 1, 40);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("prio_first_is_read", acc_wr[a0], 1'b0);
    checkOutput("prio_second_is_write", acc_wr[a0+1], 1'b1);
    checkOutput("prio_gap", acc_cyc[a0+1] - acc_cyc[a0], 5);
    checkOutput("prio_grant", g_log[base], 0);
    checkOutput("prio_rx_data", rx_data, 8'h3C);
    stepCycles(6);
    checkOutput("prio_access_count", n_acc - a0, 2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    stepCycles(6);

    // Reset asserted during TX access aborts it and reruns init
    applyStimulus(4'b1000, 1'b1, 1'b0, 8'h00, 1'b0);
    b = 30;
    while (!(PSEL && PENABLE && PWRITE) && b > 0) begin
      stepCycles(1);
      b--;
    end
    checkOutput("abort_reached_acc", (PSEL && PENABLE && PWRITE), 1'b1);
    checkOutput("abort_ready_before", req_ready, 4'b1000);
    w0 = n_wr;
    #1 PRESETN = 1'b0;
    #1;
    checkOutput("abort_psel", PSEL, 1'b0);
    checkOutput("abort_penable", PENABLE, 1'b0);
    checkOutput("abort_req_ready", req_ready, 4'b0000);
    checkOutput("abort_last_grant", last_grant, 3'd3);
    checkOutput("abort_init_done", init_done, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    stepCycles(2);
    PRESETN = 1'b1;
    stepCycles(20);
    checkOutput("reinit_writes", n_wr - w0, 2);
    checkOutput("reinit_done", init_done, 1'b1);
    checkOutput("reinit_last_grant", last_grant, 3'd3);
    base = n_tx;
    applyStimulus(4'b0011, 1'b1, 1'b0, 8'h00, 1'b0);
    waitTx("reinit_tx_wait", base + 1, 30);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reinit_first_grant", g_log[base], 0);
    stepCycles(8);
    checkOutput("reinit_last_grant_after", last_grant, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
